// File: rtl/ctrl_seq.sv
// SAP2 mini micro-sequencer: T-state counter plus 30-bit control word decode.
// Optional CTRL_SINGLE_STEP_EN adds a step input that gates state advance and con.
module ctrl_seq #(
  parameter logic ADD_M  = 1'b0,
  parameter logic ADD_CI = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [7:0]  ins,
  input  logic        am,
  input  logic        az,
  input  logic        xm,
  input  logic        xz,
  output logic [29:0] con,
  output logic        hlt
);

  localparam int LP  = 29;
  localparam int CP  = 28;
  localparam int EP  = 27;
  localparam int LS  = 26;
  localparam int ES  = 24;
  localparam int LM  = 23;
  localparam int CE  = 22;
  localparam int WE  = 21;
  localparam int LD  = 20;
  localparam int LI  = 18;
  localparam int LA  = 16;
  localparam int EA  = 15;
  localparam int LB  = 14;
  localparam int S0  = 10;
  localparam int M   = 9;
  localparam int CI  = 8;
  localparam int EU  = 7;
  localparam int LX  = 6;
  localparam int INX = 5;
  localparam int DEX = 4;
  localparam int EN  = 1;

  typedef enum logic [3:0] {
    T1, T2, T3, T4, T5, T6, T7, T8, HALT
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [29:0] cw;
  logic [3:0]  op;
  logic        cond;

  assign op = ins[7:4];

  always_comb begin
    cond = 1'b0;
    unique case (1'b1)
      (ins[5:4] == 2'd0): cond = am;
      (ins[5:4] == 2'd1): cond = az;
      (ins[5:4] == 2'd2): cond = xm;
      (ins[5:4] == 2'd3): cond = xz;
      default:            cond = 1'b0;
    endcase
  end

  always_comb begin
    cw  = '0;
    nxt = T1;
    unique case (state)
      T1: begin
        cw[EP] = 1'b1;
        cw[LM] = 1'b1;
        nxt    = T2;
      end
      T2: begin
        cw[CP] = 1'b1;
        nxt    = T3;
      end
      T3: begin
        cw[CE] = 1'b1;
        cw[LI] = 1'b1;
        nxt    = (op == 4'h0) ? T1 : T4;
      end
      T4: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h7, 4'hC: begin
            cw[EP] = 1'b1;
            cw[LM] = 1'b1;
            nxt    = T5;
          end
          4'h5: cw[INX] = 1'b1;
          4'h6: cw[DEX] = 1'b1;
          4'h8, 4'h9, 4'hA, 4'hB: begin
            // false branch just steps pc past the operand word
            if (cond) begin
              cw[EP] = 1'b1;
              cw[LM] = 1'b1;
              nxt    = T5;
            end else begin
              cw[CP] = 1'b1;
            end
          end
          4'hD: begin
            cw[ES] = 1'b1;
            cw[LP] = 1'b1;
          end
          4'hE: begin
            cw[EN] = 1'b1;
            cw[LA] = 1'b1;
          end
          4'hF: nxt = HALT;
          default: nxt = T1;
        endcase
      end
      T5: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'hC: begin
            cw[CP] = 1'b1;
            nxt    = T6;
          end
          4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
            cw[CE] = 1'b1;
            cw[LP] = 1'b1;
          end
          default: nxt = T1;
        endcase
      end
      T6: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            cw[CE] = 1'b1;
            cw[LM] = 1'b1;
            nxt    = T7;
          end
          4'hC: begin
            cw[EP] = 1'b1;
            cw[LS] = 1'b1;
            nxt    = T7;
          end
          default: nxt = T1;
        endcase
      end
      T7: begin
        case (op)
          4'h1: begin
            cw[CE] = 1'b1;
            cw[LA] = 1'b1;
          end
          4'h2: begin
            cw[EA] = 1'b1;
            cw[LD] = 1'b1;
            nxt    = T8;
          end
          4'h3: begin
            cw[CE] = 1'b1;
            cw[LB] = 1'b1;
            nxt    = T8;
          end
          4'h4: begin
            cw[CE] = 1'b1;
            cw[LX] = 1'b1;
          end
          4'hC: begin
            cw[CE] = 1'b1;
            cw[LP] = 1'b1;
          end
          default: nxt = T1;
        endcase
      end
      T8: begin
        case (op)
          4'h2: cw[WE] = 1'b1;
          4'h3: begin
            cw[EU]          = 1'b1;
            cw[LA]          = 1'b1;
            cw[S0+3:S0]     = ins[3:0];
            cw[M]           = ADD_M;
            cw[CI]          = ADD_CI;
          end
          default: nxt = T1;
        endcase
      end
      HALT: nxt = HALT;
      default: nxt = T1;
    endcase
`ifdef CTRL_SINGLE_STEP_EN
    // hold state and mute side effects between steps
    if (!step) begin
      cw  = '0;
      nxt = state;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) state <= T1;
    else     state <= nxt;
  end

  assign con = clr ? '0 : cw;
  assign hlt = (state == HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: fetch/execute control words per opcode,
// branch conditions, halt, mid-instruction clear and optional single-step.
module tb_ctrl_seq;

  localparam logic [29:0] LP  = 30'd1 << 29;
  localparam logic [29:0] CP  = 30'd1 << 28;
  localparam logic [29:0] EP  = 30'd1 << 27;
  localparam logic [29:0] LS  = 30'd1 << 26;
  localparam logic [29:0] ES  = 30'd1 << 24;
  localparam logic [29:0] LM  = 30'd1 << 23;
  localparam logic [29:0] CE  = 30'd1 << 22;
  localparam logic [29:0] WE  = 30'd1 << 21;
  localparam logic [29:0] LD  = 30'd1 << 20;
  localparam logic [29:0] ED  = 30'd1 << 19;
  localparam logic [29:0] LI  = 30'd1 << 18;
  localparam logic [29:0] EI  = 30'd1 << 17;
  localparam logic [29:0] LA  = 30'd1 << 16;
  localparam logic [29:0] EA  = 30'd1 << 15;
  localparam logic [29:0] LB  = 30'd1 << 14;
  localparam logic [29:0] S2  = 30'd1 << 12;
  localparam logic [29:0] S0  = 30'd1 << 10;
  localparam logic [29:0] EU  = 30'd1 << 7;
  localparam logic [29:0] LX  = 30'd1 << 6;
  localparam logic [29:0] INX = 30'd1 << 5;
  localparam logic [29:0] DEX = 30'd1 << 4;
  localparam logic [29:0] EX  = 30'd1 << 3;
  localparam logic [29:0] EN  = 30'd1 << 1;
  localparam logic [29:0] DRV = EP | ES | CE | ED | EI | EA | EU | EX | EN;

  logic        clk = 1'b0;
  logic        clr;
  logic        step;
  logic [7:0]  ins;
  logic        am, az, xm, xz;
  logic [29:0] con;
  logic        hlt;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cp_cnt;

  always #5 clk = ~clk;

  ctrl_seq dut (
    .clk  (clk),
    .clr  (clr),
`ifdef CTRL_SINGLE_STEP_EN
    .step (step),
`endif
    .ins  (ins),
    .am   (am),
    .az   (az),
    .xm   (xm),
    .xz   (xz),
    .con  (con),
    .hlt  (hlt)
  );

  task automatic cmp_con(input string tag, input logic [29:0] exp);
    n_cmp++;
    assert (con === exp) else begin
      n_bad++;
      $error("FAIL %s con=%h expected %h", tag, con, exp);
    end
  endtask

  task automatic cmp_hlt(input string tag, input logic exp);
    n_cmp++;
    assert (hlt === exp) else begin
      n_bad++;
      $error("FAIL %s hlt=%b expected %b", tag, hlt, exp);
    end
  endtask

  // compare this cycle's con, check bus exclusivity, then move to next cycle
  task automatic cyc(input string tag, input logic [29:0] exp);
    #1;
    cmp_con(tag, exp);
    n_cmp++;
    assert ($countones(con & DRV) <= 1) else begin
      n_bad++;
      $error("FAIL %s_drv drivers=%h expected at most one", tag, con & DRV);
    end
    if ((con & CP) != 0) cp_cnt++;
    @(negedge clk);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_t1"}, EP | LM);
    cyc({tag, "_t2"}, CP);
    cyc({tag, "_t3"}, CE | LI);
  endtask

  initial begin
    clr = 1'b1; step = 1'b1; ins = 8'h00;
    am = 1'b0; az = 1'b0; xm = 1'b0; xz = 1'b0;
    @(negedge clk);
    #1 cmp_con("clr_c1", '0);
    @(negedge clk);
    #1 cmp_con("clr_c2", '0);
    cmp_hlt("clr_hlt", 1'b0);
    clr = 1'b0;
    ins = 8'h10;
    cp_cnt = 0;
    fetch("lda");
    cyc("lda_t4", EP | LM);
    cyc("lda_t5", CP);
    cyc("lda_t6", CE | LM);
    cyc("lda_t7", CE | LA);
    n_cmp++;
    assert (cp_cnt == 2) else begin
      n_bad++;
      $error("FAIL lda_cp cnt=%0d expected 2", cp_cnt);
    end
    ins = 8'h93; az = 1'b1;
    fetch("jazt");
    cyc("jazt_t4", EP | LM);
    az = 1'b0;
    cyc("jazt_t5", CE | LP);
    fetch("jazf");
    cyc("jazf_t4", CP);
    ins = 8'h20;
    fetch("sta");
    cyc("sta_t4", EP | LM);
    cyc("sta_t5", CP);
    cyc("sta_t6", CE | LM);
    cyc("sta_t7", EA | LD);
    cyc("sta_t8", WE);
    ins = 8'h35;
    fetch("add");
    cyc("add_t4", EP | LM);
    cyc("add_t5", CP);
    cyc("add_t6", CE | LM);
    cyc("add_t7", CE | LB);
    cyc("add_t8", EU | LA | S2 | S0);
    ins = 8'hC0;
    fetch("call");
    cyc("call_t4", EP | LM);
    cyc("call_t5", CP);
    cyc("call_t6", EP | LS);
    cyc("call_t7", CE | LP);
    ins = 8'hD0;
    fetch("ret");
    cyc("ret_t4", ES | LP);
    ins = 8'h40;
    fetch("ldx");
    cyc("ldx_t4", EP | LM);
    cyc("ldx_t5", CP);
    cyc("ldx_t6", CE | LM);
    cyc("ldx_t7", CE | LX);
    ins = 8'h50;
    fetch("inx");
    cyc("inx_t4", INX);
    ins = 8'h60;
    fetch("dex");
    cyc("dex_t4", DEX);
    ins = 8'hE0;
    fetch("in");
    cyc("in_t4", EN | LA);
    ins = 8'hB0; xz = 1'b0;
    fetch("jxzf");
    cyc("jxzf_t4", CP);
    ins = 8'h00;
    fetch("nop");
    ins = 8'h10;
    cyc("abort_t1", EP | LM);
    cyc("abort_t2", CP);
    clr = 1'b1;
    cyc("abort_clr", '0);
    clr = 1'b0;
    cyc("abort_t1b", EP | LM);
    cyc("abort_t2b", CP);
    ins = 8'h00;
    cyc("abort_t3b", CE | LI);
    ins = 8'hF0;
    fetch("hlt");
    #1 cmp_hlt("hlt_t4", 1'b0);
    cyc("hlt_t4", '0);
    for (int i = 0; i < 20; i++) begin
      #1 cmp_hlt("hlt_hold", 1'b1);
      cyc("hlt_con", '0);
    end
    clr = 1'b1;
    cyc("hlt_clr", '0);
    clr = 1'b0;
    ins = 8'h00;
    #1 cmp_hlt("hlt_exit", 1'b0);
    cyc("hlt_exit_t1", EP | LM);
    cyc("hlt_exit_t2", CP);
    cyc("hlt_exit_t3", CE | LI);
`ifdef CTRL_SINGLE_STEP_EN
    cp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step = (i % 3 == 2);
      case (i / 3)
        0: cyc("ss_t1", step ? (EP | LM) : '0);
        1: cyc("ss_t2", step ? CP : '0);
        default: cyc("ss_t3", step ? (CE | LI) : '0);
      endcase
    end
    step = 1'b1;
    cyc("ss_next_t1", EP | LM);
    n_cmp++;
    assert (cp_cnt == 1) else begin
      n_bad++;
      $error("FAIL ss_cp cnt=%0d expected 1", cp_cnt);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
